hvgen_cfg: RTL and testbench
============================

Name: hvgen_cfg

Overview:
Parametrised video timing generator and RGB blanker. It is the next generation of the fixed 512x263 arcade timing block.
- Horizontal and vertical totals, active, sync and colour widths are all parameters.
- Adds runtime sync-centering offsets, selectable sync polarity, an optional interlace (alternating-field) mode and a frame-start strobe.
- Sits between the game video logic (consumes HPOS/VPOS, supplies iRGB) and the scan doubler / OSD path.

Parameters:
RGB_W, 8, colour bus width
HCNT_W, 9, horizontal counter width
VCNT_W, 9, vertical counter width
H_TOTAL, 512, pixels per line (counter wraps at H_TOTAL-1)
H_ACT_END, 337, hcnt value at which HBLK asserts
H_SYNC_START, 352, hcnt value at which HSYN goes active (before offset)
H_SYNC_END, 400, hcnt value at which HSYN goes inactive (before offset)
V_TOTAL, 263, lines per frame (even field)
V_ACT_END, 239, last active line
V_SYNC_START, 248, line at whose end VSYN goes active (before offset)
V_SYNC_END, 259, line at whose end VSYN goes inactive (before offset)
OFS_W, 4, width of signed offset inputs
SYNC_POL, 0, 0 = active-low syncs, 1 = active-high
INTERLACE, 0, 1 = odd fields have V_TOTAL+1 lines

Ports:
MCLK  in  1  master clock, sole clock
RESET  in  1  synchronous, active-high reset
PCLK_EN  in  1  pixel clock enable; all state advances only when high
HOFFSET  in  OFS_W  signed horizontal sync shift, pixels
VOFFSET  in  OFS_W  signed vertical sync shift, lines
iRGB  in  RGB_W  pixel colour from game logic
HPOS  out  HCNT_W  hcnt-1 (wrapping), combinational from counter
VPOS  out  VCNT_W  vcnt, combinational
oRGB  out  RGB_W  registered colour, zero during blanking
HBLK  out  1  horizontal blank
VBLK  out  1  vertical blank
HSYN  out  1  horizontal sync, polarity per SYNC_POL
VSYN  out  1  vertical sync, polarity per SYNC_POL
FIELD  out  1  current field (0 even, 1 odd); constant 0 when INTERLACE=0
FRAME_START  out  1  one-MCLK pulse coincident with vcnt wrap to 0

Behaviour:
- Clocking: single clock MCLK; synchronous, active-high RESET.
- RESET (priority over PCLK_EN):
  - hcnt=0, vcnt=V_TOTAL-1 (or V_TOTAL in odd field; FIELD resets to 0, so V_TOTAL-1).
  - HBLK=1, VBLK=1, HSYN/VSYN inactive, oRGB=0, FIELD=0, FRAME_START=0.
  - Latched offsets cleared to 0.
- No register changes on cycles with PCLK_EN=0. FRAME_START is forced 0 on those cycles.
- Horizontal, per enabled edge:
  - hcnt==0: HBLK<=0.
  - hcnt==H_ACT_END: HBLK<=1.
  - hcnt==H_SYNC_START+hoff_l: HSYN<=active.
  - hcnt==H_SYNC_END+hoff_l: HSYN<=inactive.
  - hcnt==H_TOTAL-1: hcnt<=0; otherwise hcnt<=hcnt+1.
  - Result: HBLK low for exactly H_ACT_END pixels per line, HPOS 0..H_ACT_END-1 while visible.
- Vertical, evaluated only on the edge where hcnt==H_TOTAL-1:
  - vcnt==V_ACT_END: VBLK<=1.
  - vcnt==V_SYNC_START+voff_l: VSYN<=active.
  - vcnt==V_SYNC_END+voff_l: VSYN<=inactive.
  - vcnt==last line (V_TOTAL-1, or V_TOTAL when INTERLACE and FIELD=1): vcnt<=0, VBLK<=0, FRAME_START<=1, FIELD<=~FIELD when INTERLACE. Otherwise vcnt<=vcnt+1.
- Offsets:
  - HOFFSET/VOFFSET are sign-extended and sampled into hoff_l/voff_l only on the frame-wrap edge, so a change never produces a partial sync mid-frame.
  - Sum arithmetic is in HCNT_W+1 / VCNT_W+1 bits.
  - Parameters plus offsets must keep sync windows inside blanking and below the total; this is checked by bench assertion, not by RTL clamping.
- Simultaneous events: if a sync edge and a blank edge share a count, both take effect on the same edge.
- oRGB<=(HBLK|VBLK)?0:iRGB on every enabled edge, using pre-update blank values: a one-pixel pipeline that matches HPOS = hcnt-1.
- Reset mid-line or mid-frame discards the partial line and restarts as after power-up. The first visible line begins one line after reset release.

Decomposition:
- Shared package holds:
  - Timing constants for the stock arcade mode (512/337/352/400, 263/239/248/259).
  - A function giving lines-per-field.
  - The sync-level helper (active/inactive from SYNC_POL).
- The two counters are structurally similar, but the vertical one is qualified by the line end; keep a single module with no sub-module.

Test Plan:
- Reset then 600 PCLK_EN pulses -> HBLK falls at the edge where hcnt goes 0->1; 337 pixels visible; HSYN active for exactly 48 enabled clocks starting after hcnt=352.
- Full frame, default params -> VBLK low for 240 lines; VSYN active 11 lines; FRAME_START pulses once per 263*512 enables.
- HOFFSET=+3 written mid-frame -> current frame HSYN unchanged; next frame HSYN window 355..403. HOFFSET=-8 -> window 344..392.
- INTERLACE=1 -> frames alternate 263 and 264 lines; FIELD toggles at each FRAME_START.
- PCLK_EN=1 every 4th MCLK with random gaps -> counts and widths identical to the continuous case; FRAME_START stays one MCLK wide.
- RESET asserted at vcnt=100, hcnt=200 -> next edge shows all outputs at their reset values; oRGB=0 while iRGB=0xFF is held in blanking.

Source files
------------

// File: rtl/hvgen_cfg_pkg.sv
// Shared timing constants and helpers for the configurable arcade video timing generator.
package hvgen_cfg_pkg;

  // Stock 512x263 arcade mode
  localparam int ARCADE_H_TOTAL      = 512;
  localparam int ARCADE_H_ACT_END    = 337;
  localparam int ARCADE_H_SYNC_START = 352;
  localparam int ARCADE_H_SYNC_END   = 400;
  localparam int ARCADE_V_TOTAL      = 263;
  localparam int ARCADE_V_ACT_END    = 239;
  localparam int ARCADE_V_SYNC_START = 248;
  localparam int ARCADE_V_SYNC_END   = 259;

  // Odd fields of an interlaced mode carry one extra line.
  function automatic int lines_per_field(input int v_total, input int interlace, input logic field);
    if (interlace != 0 && field) return v_total + 1;
    return v_total;
  endfunction

  function automatic logic sync_level(input int sync_pol, input logic active);
    return (sync_pol != 0) ? active : ~active;
  endfunction

endpackage

// File: rtl/hvgen_cfg.sv
// Parametrised video timing generator with sync centering offsets, optional
// interlace and an RGB blanker that tracks HPOS with a one-pixel pipeline.
module hvgen_cfg
  import hvgen_cfg_pkg::*;
#(
  parameter int RGB_W        = 8,
  parameter int HCNT_W       = 9,
  parameter int VCNT_W       = 9,
  parameter int H_TOTAL      = ARCADE_H_TOTAL,
  parameter int H_ACT_END    = ARCADE_H_ACT_END,
  parameter int H_SYNC_START = ARCADE_H_SYNC_START,
  parameter int H_SYNC_END   = ARCADE_H_SYNC_END,
  parameter int V_TOTAL      = ARCADE_V_TOTAL,
  parameter int V_ACT_END    = ARCADE_V_ACT_END,
  parameter int V_SYNC_START = ARCADE_V_SYNC_START,
  parameter int V_SYNC_END   = ARCADE_V_SYNC_END,
  parameter int OFS_W        = 4,
  parameter int SYNC_POL     = 0,
  parameter int INTERLACE    = 0
) (
  input  logic              MCLK,
  input  logic              RESET,
  input  logic              PCLK_EN,
  input  logic [OFS_W-1:0]  HOFFSET,
  input  logic [OFS_W-1:0]  VOFFSET,
  input  logic [RGB_W-1:0]  iRGB,
  output logic [HCNT_W-1:0] HPOS,
  output logic [VCNT_W-1:0] VPOS,
  output logic [RGB_W-1:0]  oRGB,
  output logic              HBLK,
  output logic              VBLK,
  output logic              HSYN,
  output logic              VSYN,
  output logic              FIELD,
  output logic              FRAME_START
);

  localparam logic [HCNT_W-1:0] H_LAST      = HCNT_W'(H_TOTAL - 1);
  localparam logic [HCNT_W-1:0] H_ACT       = HCNT_W'(H_ACT_END);
  localparam logic [HCNT_W-1:0] H_ONE       = HCNT_W'(1);
  localparam logic [HCNT_W:0]   H_SS        = (HCNT_W+1)'(H_SYNC_START);
  localparam logic [HCNT_W:0]   H_SE        = (HCNT_W+1)'(H_SYNC_END);
  localparam logic [VCNT_W-1:0] V_ACT       = VCNT_W'(V_ACT_END);
  localparam logic [VCNT_W-1:0] V_ONE       = VCNT_W'(1);
  localparam logic [VCNT_W:0]   V_SS        = (VCNT_W+1)'(V_SYNC_START);
  localparam logic [VCNT_W:0]   V_SE        = (VCNT_W+1)'(V_SYNC_END);
  localparam logic [VCNT_W-1:0] V_LAST_EVEN = VCNT_W'(lines_per_field(V_TOTAL, INTERLACE, 1'b0) - 1);
  localparam logic [VCNT_W-1:0] V_LAST_ODD  = VCNT_W'(lines_per_field(V_TOTAL, INTERLACE, 1'b1) - 1);
  localparam logic              SYNC_ON     = sync_level(SYNC_POL, 1'b1);
  localparam logic              SYNC_OFF    = sync_level(SYNC_POL, 1'b0);

  logic [HCNT_W-1:0] r_hcnt;
  logic [VCNT_W-1:0] r_vcnt;
  logic              r_hblk;
  logic              r_vblk;
  logic              r_hsyn;
  logic              r_vsyn;
  logic              r_field;
  logic              r_frame_start;
  logic [RGB_W-1:0]  r_rgb;
  logic [OFS_W-1:0]  r_hoff;
  logic [OFS_W-1:0]  r_voff;

  logic [HCNT_W:0]   w_hoff_x;
  logic [HCNT_W:0]   w_hcnt_x;
  logic [VCNT_W:0]   w_voff_x;
  logic [VCNT_W:0]   w_vcnt_x;
  logic [VCNT_W-1:0] w_v_last;
  logic              w_line_end;
  logic              w_frame_end;
  logic              w_hsync_on;
  logic              w_hsync_off;
  logic              w_vsync_on;
  logic              w_vsync_off;

  // Sync comparisons run one bit wider so a negative offset cannot alias.
  assign w_hoff_x    = {{(HCNT_W+1-OFS_W){r_hoff[OFS_W-1]}}, r_hoff};
  assign w_voff_x    = {{(VCNT_W+1-OFS_W){r_voff[OFS_W-1]}}, r_voff};
  assign w_hcnt_x    = {1'b0, r_hcnt};
  assign w_vcnt_x    = {1'b0, r_vcnt};
  assign w_hsync_on  = (w_hcnt_x == H_SS + w_hoff_x);
  assign w_hsync_off = (w_hcnt_x == H_SE + w_hoff_x);
  assign w_vsync_on  = (w_vcnt_x == V_SS + w_voff_x);
  assign w_vsync_off = (w_vcnt_x == V_SE + w_voff_x);

  assign w_v_last    = r_field ? V_LAST_ODD : V_LAST_EVEN;
  assign w_line_end  = (r_hcnt == H_LAST);
  assign w_frame_end = w_line_end && (r_vcnt == w_v_last);

  always_ff @(posedge MCLK) begin
    if (RESET) begin
      r_hcnt        <= '0;
      r_vcnt        <= V_LAST_EVEN;
      r_hblk        <= 1'b1;
      r_vblk        <= 1'b1;
      r_hsyn        <= SYNC_OFF;
      r_vsyn        <= SYNC_OFF;
      r_field       <= 1'b0;
      r_frame_start <= 1'b0;
      r_rgb         <= '0;
      r_hoff        <= '0;
      r_voff        <= '0;
    end else begin
      r_frame_start <= 1'b0;
      if (PCLK_EN) begin
        // Blank state before this edge gates colour, matching HPOS = hcnt-1.
        r_rgb <= (r_hblk | r_vblk) ? '0 : iRGB;

        if (r_hcnt == '0)  r_hblk <= 1'b0;
        if (r_hcnt == H_ACT) r_hblk <= 1'b1;
        if (w_hsync_on)  r_hsyn <= SYNC_ON;
        if (w_hsync_off) r_hsyn <= SYNC_OFF;

        if (w_line_end) begin
          r_hcnt <= '0;
          if (r_vcnt == V_ACT) r_vblk <= 1'b1;
          if (w_vsync_on)  r_vsyn <= SYNC_ON;
          if (w_vsync_off) r_vsyn <= SYNC_OFF;
          if (w_frame_end) begin
            r_vcnt        <= '0;
            r_vblk        <= 1'b0;
            r_frame_start <= 1'b1;
            if (INTERLACE != 0) r_field <= ~r_field;
            // Offsets only change at the frame boundary so no sync pulse is split.
            r_hoff        <= HOFFSET;
            r_voff        <= VOFFSET;
          end else begin
            r_vcnt <= r_vcnt + V_ONE;
          end
        end else begin
          r_hcnt <= r_hcnt + H_ONE;
        end
      end
    end
  end

  assign HPOS        = r_hcnt - H_ONE;
  assign VPOS        = r_vcnt;
  assign oRGB        = r_rgb;
  assign HBLK        = r_hblk;
  assign VBLK        = r_vblk;
  assign HSYN        = r_hsyn;
  assign VSYN        = r_vsyn;
  assign FIELD       = r_field;
  assign FRAME_START = r_frame_start;

endmodule

// File: tb/tb_hvgen_cfg.sv
// Bench for hvgen_cfg: stock-mode vector table, offset/reset sequences, and a
// randomized run on two small modes (progressive and interlaced) against a range-based model.
module tb_hvgen_cfg;

  logic MCLK = 1'b0;
  always #5 MCLK = ~MCLK;

  logic       RESET   = 1'b1;
  logic       PCLK_EN = 1'b0;
  logic [3:0] HOFFSET = 4'd0;
  logic [3:0] VOFFSET = 4'd0;
  logic [7:0] iRGB    = 8'd0;

  logic [8:0] d_hpos, d_vpos;
  logic [7:0] d_rgb;
  logic       d_hblk, d_vblk, d_hsyn, d_vsyn, d_field, d_fs;
  logic [5:0] s_hpos;
  logic [4:0] s_vpos;
  logic [7:0] s_rgb;
  logic       s_hblk, s_vblk, s_hsyn, s_vsyn, s_field, s_fs;
  logic [5:0] l_hpos;
  logic [4:0] l_vpos;
  logic [7:0] l_rgb;
  logic       l_hblk, l_vblk, l_hsyn, l_vsyn, l_field, l_fs;

  hvgen_cfg u_dflt (
    .MCLK(MCLK), .RESET(RESET), .PCLK_EN(PCLK_EN), .HOFFSET(HOFFSET), .VOFFSET(VOFFSET),
    .iRGB(iRGB), .HPOS(d_hpos), .VPOS(d_vpos), .oRGB(d_rgb), .HBLK(d_hblk), .VBLK(d_vblk),
    .HSYN(d_hsyn), .VSYN(d_vsyn), .FIELD(d_field), .FRAME_START(d_fs)
  );

  hvgen_cfg #(
    .HCNT_W(6), .VCNT_W(5), .H_TOTAL(64), .H_ACT_END(40), .H_SYNC_START(48), .H_SYNC_END(54),
    .V_TOTAL(24), .V_ACT_END(15), .V_SYNC_START(18), .V_SYNC_END(21), .SYNC_POL(0), .INTERLACE(0)
  ) u_small (
    .MCLK(MCLK), .RESET(RESET), .PCLK_EN(PCLK_EN), .HOFFSET(HOFFSET), .VOFFSET(VOFFSET),
    .iRGB(iRGB), .HPOS(s_hpos), .VPOS(s_vpos), .oRGB(s_rgb), .HBLK(s_hblk), .VBLK(s_vblk),
    .HSYN(s_hsyn), .VSYN(s_vsyn), .FIELD(s_field), .FRAME_START(s_fs)
  );

  hvgen_cfg #(
    .HCNT_W(6), .VCNT_W(5), .H_TOTAL(64), .H_ACT_END(40), .H_SYNC_START(48), .H_SYNC_END(54),
    .V_TOTAL(24), .V_ACT_END(15), .V_SYNC_START(18), .V_SYNC_END(21), .SYNC_POL(1), .INTERLACE(1)
  ) u_il (
    .MCLK(MCLK), .RESET(RESET), .PCLK_EN(PCLK_EN), .HOFFSET(HOFFSET), .VOFFSET(VOFFSET),
    .iRGB(iRGB), .HPOS(l_hpos), .VPOS(l_vpos), .oRGB(l_rgb), .HBLK(l_hblk), .VBLK(l_vblk),
    .HSYN(l_hsyn), .VSYN(l_vsyn), .FIELD(l_field), .FRAME_START(l_fs)
  );

  int n_checks = 0;
  int n_fails  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] pack(input logic [31:0] hpos, input logic [31:0] vpos,
                                       input logic hblk, input logic vblk, input logic hsyn,
                                       input logic vsyn, input logic field, input logic fs,
                                       input logic [31:0] rgb);
    return {18'd0, hpos[15:0], vpos[15:0], rgb[7:0], hblk, vblk, hsyn, vsyn, field, fs};
  endfunction

  // Reference model: position counters; every output is derived from where the beam is.
  typedef struct { int ht, hae, hss, hse, vt, vae, vss, vse, pol, il; } cfg_t;
  cfg_t cfg [3];
  int   m_h [3];
  int   m_v [3];
  int   m_hoff [3];
  int   m_voff [3];
  int   m_rgb [3];
  bit   m_field [3];
  bit   m_fs [3];

  function automatic int model_hpos(input int i);
    return (m_h[i] + cfg[i].ht - 1) % cfg[i].ht;
  endfunction

  function automatic bit model_blank(input int i);
    return (model_hpos(i) >= cfg[i].hae) || (m_v[i] > cfg[i].vae);
  endfunction

  function automatic logic [63:0] model_outs(input int i);
    int  hpos = model_hpos(i);
    bit  hact = (hpos >= cfg[i].hss + m_hoff[i]) && (hpos < cfg[i].hse + m_hoff[i]);
    bit  vact = (m_v[i] > cfg[i].vss + m_voff[i]) && (m_v[i] <= cfg[i].vse + m_voff[i]);
    logic hs  = (cfg[i].pol != 0) ? hact : !hact;
    logic vs  = (cfg[i].pol != 0) ? vact : !vact;
    return pack(hpos, m_v[i], hpos >= cfg[i].hae, m_v[i] > cfg[i].vae, hs, vs,
                m_field[i], m_fs[i], m_rgb[i]);
  endfunction

  task automatic model_step(input int i);
    int last;
    if (RESET) begin
      m_h[i] = 0; m_v[i] = cfg[i].vt - 1; m_field[i] = 0;
      m_hoff[i] = 0; m_voff[i] = 0; m_rgb[i] = 0; m_fs[i] = 0;
    end else begin
      m_fs[i] = 0;
      if (PCLK_EN) begin
        m_rgb[i] = model_blank(i) ? 0 : int'(iRGB);
        last = cfg[i].vt - 1 + ((cfg[i].il != 0 && m_field[i]) ? 1 : 0);
        if (m_h[i] == cfg[i].ht - 1) begin
          m_h[i] = 0;
          if (m_v[i] == last) begin
            m_v[i] = 0;
            m_fs[i] = 1;
            if (cfg[i].il != 0) m_field[i] = !m_field[i];
            m_hoff[i] = int'($signed(HOFFSET));
            m_voff[i] = int'($signed(VOFFSET));
          end else begin
            m_v[i]++;
          end
        end else begin
          m_h[i]++;
        end
      end
    end
  endtask

  bit mon_on = 0;
  int cnt_s = 0, cnt_l = 0, fr_s = 0, fr_l = 0;

  task automatic tick();
    for (int i = 0; i < 3; i++) model_step(i);
    @(posedge MCLK);
    #1;
    chk("outs dflt",  pack(32'(d_hpos), 32'(d_vpos), d_hblk, d_vblk, d_hsyn, d_vsyn, d_field, d_fs, 32'(d_rgb)), model_outs(0));
    chk("outs small", pack(32'(s_hpos), 32'(s_vpos), s_hblk, s_vblk, s_hsyn, s_vsyn, s_field, s_fs, 32'(s_rgb)), model_outs(1));
    chk("outs il",    pack(32'(l_hpos), 32'(l_vpos), l_hblk, l_vblk, l_hsyn, l_vsyn, l_field, l_fs, 32'(l_rgb)), model_outs(2));
    if (mon_on) begin
      if (RESET) begin
        cnt_s = 0; cnt_l = 0; fr_s = 0; fr_l = 0;
      end else begin
        if (PCLK_EN) begin cnt_s++; cnt_l++; end
        if (s_fs === 1'b1) begin
          if (fr_s > 0) chk("small frame len", 64'(cnt_s), 64'd1536);
          fr_s++; cnt_s = 0;
        end
        if (l_fs === 1'b1) begin
          // Frame 1 after reset is the odd field (25 lines), then alternating.
          if (fr_l > 0) chk("il frame len", 64'(cnt_l), (fr_l % 2 == 1) ? 64'd1600 : 64'd1536);
          $display("il frame %0d done, enables=%0d", fr_l, cnt_l);
          fr_l++; cnt_l = 0;
        end
      end
    end
  endtask

  task automatic wait_fs_small(input string name);
    int n = 0;
    while (s_fs !== 1'b1 && n < 4000) begin tick(); n++; end
    if (s_fs !== 1'b1) chk({name, " timeout"}, 64'(s_fs), 64'd1);
  endtask

  task automatic measure_hsync(output int start, output int width);
    int n = 0;
    start = -1; width = 0;
    while (s_hsyn !== 1'b0 && n < 200) begin tick(); n++; end
    if (s_hsyn === 1'b0) begin
      start = int'(s_hpos);
      while (s_hsyn === 1'b0 && width < 200) begin tick(); width++; end
    end
  endtask

  typedef struct {
    int         steps;
    logic [8:0] hpos;
    logic [8:0] vpos;
    logic       hblk, vblk, hsyn, fs;
    logic [7:0] rgb;
  } vec_t;
  vec_t vecs [13];

  initial begin
    int steps, hs_cnt, vis_cnt, st, wd, n;

    cfg[0] = '{512, 337, 352, 400, 263, 239, 248, 259, 0, 0};
    cfg[1] = '{64, 40, 48, 54, 24, 15, 18, 21, 0, 0};
    cfg[2] = '{64, 40, 48, 54, 24, 15, 18, 21, 1, 1};

    // Stock mode, continuous enables, iRGB=A5: {enables since reset, HPOS, VPOS, HBLK, VBLK, HSYN, FS, oRGB}
    vecs[0]  = '{0,   9'd511, 9'd262, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00};
    vecs[1]  = '{1,   9'd0,   9'd262, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
    vecs[2]  = '{337, 9'd336, 9'd262, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
    vecs[3]  = '{338, 9'd337, 9'd262, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00};
    vecs[4]  = '{352, 9'd351, 9'd262, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00};
    vecs[5]  = '{353, 9'd352, 9'd262, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[6]  = '{400, 9'd399, 9'd262, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[7]  = '{401, 9'd400, 9'd262, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00};
    vecs[8]  = '{512, 9'd511, 9'd0,   1'b1, 1'b0, 1'b1, 1'b1, 8'h00};
    vecs[9]  = '{513, 9'd0,   9'd0,   1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
    vecs[10] = '{514, 9'd1,   9'd0,   1'b0, 1'b0, 1'b1, 1'b0, 8'hA5};
    vecs[11] = '{850, 9'd337, 9'd0,   1'b1, 1'b0, 1'b1, 1'b0, 8'hA5};
    vecs[12] = '{851, 9'd338, 9'd0,   1'b1, 1'b0, 1'b1, 1'b0, 8'h00};

    // Reset with PCLK_EN high: reset must win.
    RESET = 1'b1; PCLK_EN = 1'b1; iRGB = 8'hA5;
    tick();
    RESET = 1'b0;
    steps = 0; hs_cnt = 0; vis_cnt = 0;
    for (int k = 0; k < 13; k++) begin
      while (steps < vecs[k].steps) begin
        tick();
        steps++;
        if (steps <= 512) begin
          if (d_hsyn === 1'b0) hs_cnt++;
          if (d_hblk === 1'b0) vis_cnt++;
        end
      end
      chk($sformatf("vec%0d hpos", k), 64'(d_hpos), 64'(vecs[k].hpos));
      chk($sformatf("vec%0d vpos", k), 64'(d_vpos), 64'(vecs[k].vpos));
      chk($sformatf("vec%0d hblk", k), 64'(d_hblk), 64'(vecs[k].hblk));
      chk($sformatf("vec%0d vblk", k), 64'(d_vblk), 64'(vecs[k].vblk));
      chk($sformatf("vec%0d hsyn", k), 64'(d_hsyn), 64'(vecs[k].hsyn));
      chk($sformatf("vec%0d fs",   k), 64'(d_fs),   64'(vecs[k].fs));
      chk($sformatf("vec%0d rgb",  k), 64'(d_rgb),  64'(vecs[k].rgb));
      $display("vec %0d: %0d enables, hpos=%0d vpos=%0d", k, steps, d_hpos, d_vpos);
    end
    chk("hsync width first line", 64'(hs_cnt), 64'd48);
    chk("visible pixels first line", 64'(vis_cnt), 64'd337);

    // Offset latching on the small mode with continuous enables.
    RESET = 1'b1; tick(); RESET = 1'b0;
    HOFFSET = 4'd0; VOFFSET = 4'd0;
    wait_fs_small("fs wait A");
    repeat (5 * 64 + 10) tick();
    HOFFSET = 4'd3;
    measure_hsync(st, wd);
    chk("hsync start same frame", 64'(st), 64'd48);
    chk("hsync width same frame", 64'(wd), 64'd6);
    $display("hoffset +3 mid-frame: start=%0d width=%0d", st, wd);
    wait_fs_small("fs wait B");
    measure_hsync(st, wd);
    chk("hsync start +3", 64'(st), 64'd51);
    chk("hsync width +3", 64'(wd), 64'd6);
    $display("hoffset +3 next frame: start=%0d width=%0d", st, wd);
    HOFFSET = 4'b1000;
    repeat (3 * 64) tick();
    wait_fs_small("fs wait C");
    measure_hsync(st, wd);
    chk("hsync start -8", 64'(st), 64'd40);
    chk("hsync width -8", 64'(wd), 64'd6);
    $display("hoffset -8 next frame: start=%0d width=%0d", st, wd);

    // Reset in the middle of the frame, with white held on iRGB.
    HOFFSET = 4'd0;
    n = 0;
    while (!(m_v[1] == 10 && m_h[1] == 30) && n < 3000) begin tick(); n++; end
    chk("reach v10 h30", 64'(m_v[1] == 10 && m_h[1] == 30), 64'd1);
    iRGB = 8'hFF; RESET = 1'b1;
    tick();
    chk("reset mid-frame", pack(32'(s_hpos), 32'(s_vpos), s_hblk, s_vblk, s_hsyn, s_vsyn, s_field, s_fs, 32'(s_rgb)),
        pack(32'd63, 32'd23, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0));
    RESET = 1'b0;
    for (int k = 0; k < 65; k++) begin
      tick();
      chk("rgb blank after reset", 64'(s_rgb), 64'd0);
    end
    tick();
    chk("first visible rgb", 64'(s_rgb), 64'hFF);
    $display("mid-frame reset sequence done");

    // Randomized: sparse pixel enables, random colour and offsets, interlace frame lengths.
    mon_on = 1'b1;
    RESET = 1'b1; PCLK_EN = 1'b0; tick(); RESET = 1'b0;
    for (int c = 0; c < 45000 && fr_l < 5 && n_fails < 100; c++) begin
      PCLK_EN = (c % 4 == 0) && ($urandom_range(0, 7) != 0);
      iRGB = 8'($urandom);
      if ($urandom_range(0, 299) == 0) HOFFSET = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 299) == 0) VOFFSET = 4'($urandom_range(0, 5) - 3);
      tick();
    end
    mon_on = 1'b0;
    chk("il frames seen", 64'(fr_l), 64'd5);
    chk("small frames seen", 64'(fr_s >= 5), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
